// File: rtl/y_cpu_pkg.sv
// y_cpu_pkg: op encodings and FSM state type shared by the muldiv unit.
package y_cpu_pkg;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/y_muldiv_step.sv
// y_muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration.
module y_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // hi:lo is the product while multiplying, remainder:quotient while dividing
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    rsh  = {hi_i, lo_i[WIDTH-1]};
    ge   = rsh >= {1'b0, m_i};
    diff = rsh[WIDTH-1:0] - m_i;
    hi_o = div_i ? (ge ? diff : rsh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_o = div_i ? {lo_i[WIDTH-2:0], ge} : {sum[0], lo_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/y_muldiv.sv
// y_muldiv: iterative unsigned multiply/divide unit, one step per cycle.
module y_muldiv
  import y_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, z_q, z_d;
  logic [WIDTH-1:0] step_hi, step_lo, res;
  logic             zero_q, zero_d, dz_q, dz_d, is_div;
  assign is_div    = op_q == OP_DIVU || op_q == OP_REMU;
  assign res       = (op_q == OP_MULHU || op_q == OP_REMU) ? hi_q : lo_q;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign z         = z_q;
  assign zero      = zero_q;
  assign dz        = dz_q;
  y_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i(is_div),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .m_i  (m_q),
    .hi_o (step_hi),
    .lo_o (step_lo)
  );
  // m holds the multiplicand or the divisor; lo starts as multiplier or dividend
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    z_d     = z_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_d = BUSY;
          op_d    = op_e'(op);
          cnt_d   = '0;
          m_d     = op[1] ? b : a;
          hi_d    = '0;
          lo_d    = op[1] ? a : b;
        end
        BUSY: if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          z_d     = res;
          zero_d  = res == '0;
          dz_d    = is_div && m_q == '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: doc/y_muldiv.md
Y_MULDIV -- requirements
Module: y_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; legal range 8..64.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 in_valid  input  1  request present on a, b, op.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 a  input  WIDTH  multiplicand or dividend, unsigned.
REQ-007 b  input  WIDTH  multiplier or divisor, unsigned.
REQ-008 op  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU.
REQ-009 flush  input  1  abort any in-flight or held operation.
REQ-010 out_valid  output  1  result held on z.
REQ-011 out_ready  input  1  consumer accepts z this cycle.
REQ-012 z  output  WIDTH  selected result.
REQ-013 zero  output  1  z equals 0, valid when out_valid is high.
REQ-014 dz  output  1  DIVU/REMU was issued with b equal to 0, valid when out_valid is high.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-016 In IDLE: in_ready=1; in_valid=1 captures a, b, op, clears the iteration counter, and moves to BUSY.
REQ-017 In BUSY: in_ready=0; exactly one shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU) step per cycle; after WIDTH steps the FSM moves to DONE.
REQ-018 Latency: request accepted at edge N -> out_valid high from edge N+WIDTH+1.
REQ-019 In DONE: out_valid=1; z, zero and dz stay stable until out_ready=1; in_ready=0.
REQ-020 DONE with out_ready=1 -> IDLE next cycle; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 Multiply SHALL form a 2*WIDTH-bit product; MUL returns bits [WIDTH-1:0], MULHU returns bits [2*WIDTH-1:WIDTH].
REQ-022 DIVU SHALL return floor(a/b); REMU SHALL return a mod b.
REQ-023 Divide by zero SHALL still take the full latency and return z = all ones (DIVU) or z = a (REMU), with dz=1.
REQ-024 The iteration counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap before the step count reaches WIDTH.
REQ-025 flush=1 in any state -> IDLE next cycle, out_valid=0, and the result is discarded; flush has priority over in_valid and out_ready.
REQ-026 in_valid and flush high together in IDLE -> the request is dropped.
REQ-027 a and b changing during BUSY or DONE SHALL have no effect.
REQ-028 op values are fully decoded; there is no illegal encoding.

Reset
REQ-029 rst_n=0 -> state IDLE, in_ready=1, out_valid=0, z=0, zero=0, dz=0, counter and operand registers 0, regardless of the clock.
REQ-030 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; no result appears after release.
REQ-031 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package y_cpu_pkg SHALL hold the op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU) and the state type (IDLE/BUSY/DONE).
REQ-033 One combinational sub-module, y_muldiv_step (parametrised by WIDTH), SHALL compute a single multiply or divide iteration; y_muldiv holds the FSM, counter and registers.
REQ-034 z, zero and dz SHALL be driven from registers, not from combinational logic.

Verification
REQ-035 WIDTH=32, a=7, b=6, op=MUL -> z=42, zero=0, out_valid first high 33 cycles after acceptance.
REQ-036 a=32'hFFFFFFFF, b=32'hFFFFFFFF, op=MULHU -> z=32'hFFFFFFFE; same operands with op=MUL -> z=1.
REQ-037 a=100, b=7: DIVU -> z=14, REMU -> z=2; a=5, b=0: DIVU -> z=32'hFFFFFFFF with dz=1, REMU -> z=5 with dz=1.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> z held stable and in_ready=0; a new in_valid is not accepted until out_ready=1.
REQ-039 Assert flush at BUSY step 5 -> IDLE next cycle, no out_valid pulse; reset mid-BUSY -> all outputs return to reset values immediately.
REQ-040 Run at WIDTH=8 and WIDTH=64 with 1000 random operands per op against a reference model, including a=0 and b=1 corners.
